// File: rtl/iomem_led_pwm.sv
// iomem_led_pwm -- memory-mapped PWM LED controller on the PicoSoC iomem bus.
//
// Decodes one 16 MB page (iomem_addr[31:24] == BASE_PAGE). Each request gets
// a single-cycle iomem_ready pulse one cycle later. Up to 8 channels get an
// 8-bit duty cycle. The duty is shadowed so that it only changes at a period
// wrap, which keeps the LED outputs glitch-free.
//
// Optional feature macro: IOMEM_LED_PWM_BREATHE_EN
//   When defined, CTRL.BREATHE and BREATHE_MASK add a triangle-wave duty
//   ramp that channels can select. When undefined, bit2 and offset 3 read
//   as 0 and no breathe logic exists.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   iomem_valid  bus request valid
//   iomem_ready  one-cycle acknowledge pulse
//   iomem_wstrb  byte write strobes, 0 = read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready = 1
//   pwm_out      registered LED drive, one bit per channel

module iomem_led_pwm #(
  parameter int          NUM_CH       = 8,
  parameter logic [7:0]  BASE_PAGE    = 8'h06,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic [NUM_CH-1:0] pwm_out
);

  logic              r_ready;
  logic [31:0]       r_rdata;
  logic [NUM_CH-1:0] r_pwm;
  logic              r_en;
  logic              r_inv;
  logic [15:0]       r_prescale;
  logic [15:0]       r_pre_cnt;
  logic [7:0]        r_cnt;
  logic [7:0]        r_period;
  logic [7:0]        r_pend [NUM_CH];
  logic [7:0]        r_act  [NUM_CH];

`ifdef IOMEM_LED_PWM_BREATHE_EN
  logic              r_breathe;
  logic [NUM_CH-1:0] r_mask;
  logic [7:0]        r_br_level;
  logic              r_br_down;
  logic [7:0]        w_br_next;
  logic              w_br_down_next;
`endif

  logic        w_sel;
  logic        w_wr;
  logic [3:0]  w_off;
  logic        w_tick;
  logic        w_wrap;
  logic [31:0] w_rd_val;
  logic        w_unused_bits;

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign pwm_out     = r_pwm;

  // Bits that no register consumes in some configurations.
  assign w_unused_bits = ^{iomem_wdata, iomem_addr[23:6], iomem_addr[1:0]};

  always_comb begin
    // !r_ready makes a held request acknowledge once, then re-arm a cycle later.
    w_sel  = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_PAGE);
    w_wr   = w_sel && (iomem_wstrb != 4'b0000);
    w_off  = iomem_addr[5:2];
    // Equality compare: if PRESCALE is lowered below the running count, the
    // counter runs on to 16'hFFFF and wraps naturally.
    w_tick = r_en && (r_pre_cnt == r_prescale);
    w_wrap = w_tick && (r_cnt == 8'hFF);

    w_rd_val = '0;
    case (w_off)
`ifdef IOMEM_LED_PWM_BREATHE_EN
      4'd0: w_rd_val = {29'b0, r_breathe, r_inv, r_en};
      4'd3: w_rd_val[NUM_CH-1:0] = r_mask;
`else
      4'd0: w_rd_val = {30'b0, r_inv, r_en};
`endif
      4'd1: w_rd_val = {16'b0, r_prescale};
      4'd2: w_rd_val = {16'b0, r_period, r_cnt};
      default: begin
        if (w_off[3]) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (w_off[2:0] == 3'(i)) w_rd_val = {24'b0, r_pend[i]};
          end
        end
      end
    endcase
  end

`ifdef IOMEM_LED_PWM_BREATHE_EN
  // Triangle ramp 0..255..0: the turn-around steps straight to 254 / 1 so the
  // end points are each held for only one period.
  always_comb begin
    w_br_next      = r_br_level;
    w_br_down_next = r_br_down;
    if (!r_br_down) begin
      if (r_br_level == 8'hFF) begin
        w_br_next      = 8'hFE;
        w_br_down_next = 1'b1;
      end else begin
        w_br_next = r_br_level + 8'd1;
      end
    end else begin
      if (r_br_level == 8'h00) begin
        w_br_next      = 8'h01;
        w_br_down_next = 1'b0;
      end else begin
        w_br_next = r_br_level - 8'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_pwm      <= '0;
      r_en       <= 1'b0;
      r_inv      <= 1'b0;
      r_prescale <= PRESCALE_RST;
      r_pre_cnt  <= '0;
      r_cnt      <= '0;
      r_period   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_pend[i] <= '0;
        r_act[i]  <= '0;
      end
`ifdef IOMEM_LED_PWM_BREATHE_EN
      r_breathe  <= 1'b0;
      r_mask     <= '0;
      r_br_level <= '0;
      r_br_down  <= 1'b0;
`endif
    end else begin
      r_ready <= w_sel;
      r_rdata <= w_sel ? w_rd_val : 32'h0;

      if (w_wr) begin
        case (w_off)
          4'd0: begin
            if (iomem_wstrb[0]) begin
              r_en  <= iomem_wdata[0];
              r_inv <= iomem_wdata[1];
`ifdef IOMEM_LED_PWM_BREATHE_EN
              r_breathe <= iomem_wdata[2];
`endif
            end
          end
          4'd1: begin
            if (iomem_wstrb[0]) r_prescale[7:0]  <= iomem_wdata[7:0];
            if (iomem_wstrb[1]) r_prescale[15:8] <= iomem_wdata[15:8];
          end
`ifdef IOMEM_LED_PWM_BREATHE_EN
          4'd3: begin
            if (iomem_wstrb[0]) r_mask <= iomem_wdata[NUM_CH-1:0];
          end
`endif
          default: begin
            if (w_off[3] && iomem_wstrb[0]) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (w_off[2:0] == 3'(i)) r_pend[i] <= iomem_wdata[7:0];
              end
            end
          end
        endcase
      end

      if (!r_en) begin
        r_pre_cnt <= '0;
        r_cnt     <= '0;
      end else if (w_tick) begin
        r_pre_cnt <= '0;
        r_cnt     <= r_cnt + 8'd1;
        if (w_wrap) r_period <= r_period + 8'd1;
      end else begin
        r_pre_cnt <= r_pre_cnt + 16'd1;
      end

      // r_pend on the right-hand side is the pre-write value, so a DUTY write
      // landing on the wrap edge only takes effect one period later.
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef IOMEM_LED_PWM_BREATHE_EN
        if (r_breathe && r_mask[i]) begin
          if (!r_en)       r_act[i] <= r_br_level;
          else if (w_wrap) r_act[i] <= w_br_next;
        end else
`endif
        if (!r_en || w_wrap) r_act[i] <= r_pend[i];
      end

      for (int i = 0; i < NUM_CH; i++) begin
        r_pwm[i] <= r_en ? ((r_cnt < r_act[i]) ^ r_inv) : r_inv;
      end

`ifdef IOMEM_LED_PWM_BREATHE_EN
      if (!r_breathe) begin
        r_br_level <= '0;
        r_br_down  <= 1'b0;
      end else if (w_wrap) begin
        r_br_level <= w_br_next;
        r_br_down  <= w_br_down_next;
      end
`endif
    end
  end

endmodule

// File: tb/tb_iomem_led_pwm.sv
module tb_iomem_led_pwm;

  localparam int          NUM_CH = 4;
  localparam logic [15:0] PS_RST = 16'h0005;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              iomem_valid = 1'b0;
  logic              iomem_ready;
  logic [3:0]        iomem_wstrb = 4'b0;
  logic [31:0]       iomem_addr = 32'h0;
  logic [31:0]       iomem_wdata = 32'h0;
  logic [31:0]       iomem_rdata;
  logic [NUM_CH-1:0] pwm_out;

  int n_vec = 0;
  int n_err = 0;

  iomem_led_pwm #(
    .NUM_CH(NUM_CH),
    .BASE_PAGE(8'h06),
    .PRESCALE_RST(PS_RST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A_CTRL = 32'h0600_0000;
  localparam logic [31:0] A_PS   = 32'h0600_0004;
  localparam logic [31:0] A_STAT = 32'h0600_0008;
  localparam logic [31:0] A_D0   = 32'h0600_0020;
  localparam logic [31:0] A_D1   = 32'h0600_0024;
  localparam logic [31:0] A_D2   = 32'h0600_0028;
  localparam logic [31:0] A_D3   = 32'h0600_002C;

  // One bus transaction; lat = cycles until ready seen, -1 if never.
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd, output int lat);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    lat = -1;
    rd  = 32'hDEAD_BEEF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (iomem_ready === 1'b1) begin
        lat = k;
        rd  = iomem_rdata;
        break;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    bus(a, 4'b1111, d, rd, lat);
  endtask

  task automatic count_win(input int n, output int c0, output int c1, output int c2, output int c3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      c0 += int'(pwm_out[0]);
      c1 += int'(pwm_out[1]);
      c2 += int'(pwm_out[2]);
      c3 += int'(pwm_out[3]);
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    int lat;
    int bad;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (iomem_ready !== 1'b0 || pwm_out !== 4'h0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL reset_idle: %0d idle cycles with ready/pwm nonzero, required 0", bad);
    end
    bus(A_CTRL, 4'b0, 32'h0, rd, lat);
    n_vec++;
    if (lat !== 1 || rd !== 32'h0) begin
      n_err++;
      $display("FAIL reset_ctrl: lat=%0d rdata=%h, required lat=1 rdata=0", lat, rd);
    end
    bus(A_PS, 4'b0, 32'h0, rd, lat);
    n_vec++;
    if (lat !== 1 || rd !== 32'h0000_0005) begin
      n_err++;
      $display("FAIL reset_prescale: lat=%0d rdata=%h, required lat=1 rdata=5", lat, rd);
    end
    bus(A_D0, 4'b0, 32'h0, rd, lat);
    n_vec++;
    if (lat !== 1 || rd !== 32'h0) begin
      n_err++;
      $display("FAIL reset_duty0: lat=%0d rdata=%h, required lat=1 rdata=0", lat, rd);
    end
  endtask

  task automatic test_pwm;
    int c0, c1, c2, c3;
    wr(A_PS, 32'h0);
    wr(A_D0, 32'd64);
    wr(A_D1, 32'd0);
    wr(A_D2, 32'd255);
    wr(A_D3, 32'd128);
    wr(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      count_win(256, c0, c1, c2, c3);
      n_vec++;
      if (c0 !== 64) begin
        n_err++;
        $display("FAIL pwm_duty64 win%0d: high=%0d, required 64", w, c0);
      end
      n_vec++;
      if (c1 !== 0 || c3 !== 128) begin
        n_err++;
        $display("FAIL pwm_duty0_128 win%0d: high=%0d/%0d, required 0/128", w, c1, c3);
      end
      n_vec++;
      if (c2 !== 255) begin
        n_err++;
        $display("FAIL pwm_duty255 win%0d: high=%0d, required 255", w, c2);
      end
    end
  endtask

  task automatic test_mid_period;
    logic [31:0] rd;
    int lat, tries, early, found, c0, c1, c2, c3;
    logic prev;
    tries = 0;
    rd = 32'h0;
    while (tries < 400) begin
      bus(A_STAT, 4'b0, 32'h0, rd, lat);
      if (rd[7:0] >= 8'd80 && rd[7:0] <= 8'd140) break;
      tries++;
    end
    n_vec++;
    if (tries >= 400) begin
      n_err++;
      $display("FAIL mid_status_poll: last cnt=%0d, required a value in 80..140", rd[7:0]);
    end
    wr(A_D0, 32'd200);
    early = 0;
    repeat (40) begin
      @(negedge clk);
      early += int'(pwm_out[0]);
    end
    n_vec++;
    if (early !== 0) begin
      n_err++;
      $display("FAIL mid_keep_period: high=%0d after mid-period write, required 0", early);
    end
    found = 0;
    prev = pwm_out[0];
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (pwm_out[0] && !prev) begin
        found = 1;
        break;
      end
      prev = pwm_out[0];
    end
    n_vec++;
    if (found !== 1) begin
      n_err++;
      $display("FAIL mid_next_period: no rising edge in 600 cycles, required one");
    end
    count_win(255, c0, c1, c2, c3);
    n_vec++;
    if (c0 + 1 !== 200) begin
      n_err++;
      $display("FAIL mid_new_duty: high=%0d, required 200", c0 + 1);
    end
    count_win(256, c0, c1, c2, c3);
    n_vec++;
    if (c0 !== 200) begin
      n_err++;
      $display("FAIL mid_new_duty2: high=%0d, required 200", c0);
    end
  endtask

  task automatic test_decode;
    logic [31:0] rd;
    int lat, seen;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0700_0000;
    iomem_wstrb = 4'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (iomem_ready !== 1'b0) seen++;
    end
    iomem_valid = 1'b0;
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL decode_other_page: ready seen %0d times, required 0", seen);
    end
    bus(32'h0600_0030, 4'b0, 32'h0, rd, lat);
    n_vec++;
    if (lat !== 1 || rd !== 32'h0) begin
      n_err++;
      $display("FAIL decode_off12: lat=%0d rdata=%h, required lat=1 rdata=0", lat, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] pat;
    logic [31:0] rd0;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = A_D0;
    iomem_wstrb = 4'b0;
    rd0 = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat[3-k] = iomem_ready;
      if (k == 0) rd0 = iomem_rdata;
    end
    iomem_valid = 1'b0;
    n_vec++;
    if (pat !== 4'b1010) begin
      n_err++;
      $display("FAIL b2b_ready_pattern: %b, required 1010", pat);
    end
    n_vec++;
    if (rd0 !== 32'd200) begin
      n_err++;
      $display("FAIL b2b_rdata: %0d, required 200", rd0);
    end
  endtask

  task automatic test_partial_inv;
    logic [31:0] rd;
    int lat, found, len, c0, c1, c2;
    logic prev;
    bus(A_PS, 4'b0001, 32'hABCD_1203, rd, lat);
    bus(A_CTRL, 4'b0001, 32'hFFFF_FF03, rd, lat);
    bus(A_PS, 4'b0, 32'h0, rd, lat);
    n_vec++;
    if (rd !== 32'h3) begin
      n_err++;
      $display("FAIL partial_prescale: %h, required 00000003", rd);
    end
    bus(A_CTRL, 4'b0, 32'h0, rd, lat);
    n_vec++;
    if (rd !== 32'h3) begin
      n_err++;
      $display("FAIL partial_ctrl: %h, required 00000003", rd);
    end
    found = 0;
    prev = pwm_out[0];
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (pwm_out[0] && !prev) begin
        found = 1;
        break;
      end
      prev = pwm_out[0];
    end
    len = 0; c0 = 1; c1 = int'(pwm_out[1]); c2 = int'(pwm_out[2]);
    prev = pwm_out[0];
    if (found == 1) begin
      found = 0;
      for (int k = 1; k < 1100; k++) begin
        @(negedge clk);
        if (pwm_out[0] && !prev) begin
          found = 1;
          len = k;
          break;
        end
        prev = pwm_out[0];
        c0 += int'(pwm_out[0]);
        c1 += int'(pwm_out[1]);
        c2 += int'(pwm_out[2]);
      end
    end
    n_vec++;
    if (found !== 1 || len !== 1024) begin
      n_err++;
      $display("FAIL inv_period: length=%0d found=%0d, required 1024", len, found);
    end
    n_vec++;
    if (c0 !== 224 || c1 !== 1024 || c2 !== 4) begin
      n_err++;
      $display("FAIL inv_high_counts: %0d/%0d/%0d, required 224/1024/4", c0, c1, c2);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int lat;
    repeat (300) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (pwm_out !== 4'h0 || iomem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_pwm: pwm=%h ready=%b, required 0/0", pwm_out, iomem_ready);
    end
    reset = 1'b0;
    bus(A_CTRL, 4'b0, 32'h0, rd, lat);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_ctrl: %h, required 0", rd);
    end
    bus(A_PS, 4'b0, 32'h0, rd, lat);
    n_vec++;
    if (rd !== 32'h5) begin
      n_err++;
      $display("FAIL reset_mid_prescale: %h, required 5", rd);
    end
    bus(A_D2, 4'b0, 32'h0, rd, lat);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_duty2: %h, required 0", rd);
    end
    bus(A_STAT, 4'b0, 32'h0, rd, lat);
    n_vec++;
    if (rd[7:0] !== 8'h0 || pwm_out !== 4'h0) begin
      n_err++;
      $display("FAIL reset_mid_status: cnt=%0d pwm=%h, required 0/0", rd[7:0], pwm_out);
    end
  endtask

  task automatic test_disabled_inv;
    wr(A_D0, 32'd100);
    wr(A_CTRL, 32'h2);
    repeat (3) @(negedge clk);
    n_vec++;
    if (pwm_out !== 4'hF) begin
      n_err++;
      $display("FAIL disabled_inv: pwm=%h, required f", pwm_out);
    end
  endtask

  initial begin
    test_reset;
    test_pwm;
    test_mid_period;
    test_decode;
    test_back_to_back;
    test_partial_inv;
    test_reset_mid;
    test_disabled_inv;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
